// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared state encoding and widths for the data-memory port arbiter.
package dmem_port_arbiter_pkg;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int MEM_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } arb_state_t;
endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating count of cycles the DMA requester has been refused.
module arb_starve_ctr
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    logic [7:0] cnt;

    assign at_max = cnt == 8'(MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU MEM stage and a DMA requester.
// Optional DMEM_ARB_STATS_EN adds saturating stall-cycle and DMA-grant counters.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_valid,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_stall_cyc,
    output logic [15:0]       stat_dma_grants
`endif
);
    arb_state_t        state, next_state;
    logic [2:0]        lat_cnt;
    logic              own_we;
    logic [DATA_W-1:0] rdata_q;
    logic              at_max;
    logic              grant_cpu, grant_dma, last, cpu_done, dma_done, cpu_load_done;

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        grant_cpu     = reset && state == IDLE && cpu_req && (!at_max || !dma_valid);
        grant_dma     = reset && state == IDLE && !grant_cpu && dma_valid;
        last          = lat_cnt == 3'(MEM_LAT);
        cpu_done      = state == BUSY_CPU && last;
        dma_done      = state == BUSY_DMA && last;
        cpu_load_done = cpu_done && !own_we && cpu_req;
        next_state    = grant_cpu ? BUSY_CPU :
                        grant_dma ? BUSY_DMA :
                        (state != IDLE && last) ? IDLE : state;
        mem_en        = grant_cpu || grant_dma;
        mem_we        = grant_cpu ? cpu_we : grant_dma && dma_we;
        mem_addr      = grant_cpu ? cpu_addr : grant_dma ? dma_addr : '0;
        mem_wdata     = grant_cpu ? cpu_wdata : grant_dma ? dma_wdata : '0;
        dma_ready     = grant_dma;
        dma_rvalid    = dma_done;
        dma_rdata     = dma_done ? mem_rdata : '0;
        cpu_rdata     = cpu_load_done ? mem_rdata : rdata_q;
        cpu_stall     = reset && cpu_req && !cpu_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            own_we  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= next_state;
            lat_cnt <= mem_en ? 3'd1 : (state != IDLE && !last) ? lat_cnt + 3'd1 : 3'd0;
            own_we  <= grant_cpu ? cpu_we : grant_dma ? dma_we : own_we;
            if (cpu_load_done)
                rdata_q <= mem_rdata;
        end
    end

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (dma_valid && (grant_cpu || state == BUSY_CPU)),
        .clr   (grant_dma || !dma_valid),
        .at_max(at_max)
    );

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_stall_cyc  <= '0;
            stat_dma_grants <= '0;
        end else begin
            if (cpu_stall && stat_stall_cyc != '1)
                stat_stall_cyc <= stat_stall_cyc + 32'd1;
            if (grant_dma && stat_dma_grants != '1)
                stat_dma_grants <= stat_dma_grants + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: three arbiter instances (MEM_LAT 1/3/2) checked every cycle against a
// timestamp-based model, plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req [N], cpu_we [N], dma_valid [N], dma_we [N];
    logic [31:0] cpu_addr [N], cpu_wdata [N], dma_addr [N], dma_wdata [N];
    logic [31:0] cpu_rdata [N], dma_rdata [N], mem_addr [N], mem_wdata [N], mem_rdata [N], last_addr [N];
    logic        cpu_stall [N], dma_ready [N], dma_rvalid [N], mem_en [N], mem_we [N];
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_stall_cyc [N];
    logic [15:0] stat_dma_grants [N];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_port_arbiter #(.MEM_LAT(g == 0 ? 1 : g == 1 ? 3 : 2), .STARVE_MAX(g == 2 ? 3 : 8)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .dma_valid (dma_valid[g]),
            .dma_we    (dma_we[g]),
            .dma_addr  (dma_addr[g]),
            .dma_wdata (dma_wdata[g]),
            .dma_ready (dma_ready[g]),
            .dma_rvalid(dma_rvalid[g]),
            .dma_rdata (dma_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
`ifdef DMEM_ARB_STATS_EN
            ,
            .stat_stall_cyc (stat_stall_cyc[g]),
            .stat_dma_grants(stat_dma_grants[g])
`endif
        );
    end

    function automatic int lat_of(input int i);
        return i == 0 ? 1 : i == 1 ? 3 : 2;
    endfunction

    function automatic int smax_of(input int i);
        return i == 2 ? 3 : 8;
    endfunction

    // Memory content is a fixed function of address; read data stays valid from cycle 1 on.
    function automatic logic [31:0] rd(input logic [31:0] a);
        return a == 32'h10 ? 32'hDEADBEEF : a == 32'h40 ? 32'hCAFEF00D : {a[15:0], ~a[15:0]};
    endfunction

    always_comb
        for (int i = 0; i < N; i++)
            mem_rdata[i] = rd(last_addr[i]);

    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (!reset)
                last_addr[i] <= '0;
            else if (mem_en[i])
                last_addr[i] <= mem_addr[i];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    int          cyc = 0;
    int          m_owner [N], m_t0 [N], m_starve [N], m_stall_n [N], m_grants [N];
    logic        m_we [N];
    logic [31:0] m_addr [N], m_held [N];
    logic        e_cw [N], e_dw [N], e_done [N], e_stall [N];
    logic        busy, cd;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                e_cw[i] = 0; e_dw[i] = 0; e_done[i] = 0; e_stall[i] = 0;
                chk("rst_mem_en", i, 32'(mem_en[i]), 0);
                chk("rst_mem_we", i, 32'(mem_we[i]), 0);
                chk("rst_mem_addr", i, mem_addr[i], 0);
                chk("rst_mem_wdata", i, mem_wdata[i], 0);
                chk("rst_cpu_rdata", i, cpu_rdata[i], 0);
                chk("rst_cpu_stall", i, 32'(cpu_stall[i]), 0);
                chk("rst_dma_ready", i, 32'(dma_ready[i]), 0);
                chk("rst_dma_rvalid", i, 32'(dma_rvalid[i]), 0);
                chk("rst_dma_rdata", i, dma_rdata[i], 0);
            end else begin
                busy       = m_owner[i] != 0;
                e_done[i]  = busy && (cyc - m_t0[i]) == lat_of(i);
                e_cw[i]    = !busy && cpu_req[i] && (m_starve[i] < smax_of(i) || !dma_valid[i]);
                e_dw[i]    = !busy && !e_cw[i] && dma_valid[i];
                cd         = e_done[i] && m_owner[i] == 1;
                e_stall[i] = cpu_req[i] && !cd;
                chk("mem_en", i, 32'(mem_en[i]), 32'(e_cw[i] || e_dw[i]));
                if (e_cw[i]) begin
                    chk("mem_we_cpu", i, 32'(mem_we[i]), 32'(cpu_we[i]));
                    chk("mem_addr_cpu", i, mem_addr[i], cpu_addr[i]);
                    chk("mem_wdata_cpu", i, mem_wdata[i], cpu_wdata[i]);
                end
                if (e_dw[i]) begin
                    chk("mem_we_dma", i, 32'(mem_we[i]), 32'(dma_we[i]));
                    chk("mem_addr_dma", i, mem_addr[i], dma_addr[i]);
                    chk("mem_wdata_dma", i, mem_wdata[i], dma_wdata[i]);
                end
                chk("dma_ready", i, 32'(dma_ready[i]), 32'(e_dw[i]));
                chk("cpu_stall", i, 32'(cpu_stall[i]), 32'(e_stall[i]));
                chk("dma_rvalid", i, 32'(dma_rvalid[i]), 32'(e_done[i] && m_owner[i] == 2));
                if (e_done[i] && m_owner[i] == 2)
                    chk("dma_rdata", i, dma_rdata[i], rd(m_addr[i]));
                chk("cpu_rdata", i, cpu_rdata[i], (cd && !m_we[i] && cpu_req[i]) ? rd(m_addr[i]) : m_held[i]);
            end
`ifdef DMEM_ARB_STATS_EN
            chk("stat_stall_cyc", i, stat_stall_cyc[i], reset ? 32'(m_stall_n[i]) : 0);
            chk("stat_dma_grants", i, 32'(stat_dma_grants[i]), reset ? 32'(m_grants[i]) : 0);
`endif
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                m_owner[i] = 0; m_t0[i] = 0; m_starve[i] = 0; m_stall_n[i] = 0; m_grants[i] = 0;
                m_we[i] = 0; m_addr[i] = 0; m_held[i] = 0;
                e_cw[i] = 0; e_dw[i] = 0; e_done[i] = 0; e_stall[i] = 0;
            end else begin
                if (!dma_valid[i] || e_dw[i])
                    m_starve[i] = 0;
                else if ((e_cw[i] || m_owner[i] == 1) && m_starve[i] < smax_of(i))
                    m_starve[i]++;
                if (e_stall[i])
                    m_stall_n[i]++;
                if (e_done[i]) begin
                    if (m_owner[i] == 1 && !m_we[i] && cpu_req[i])
                        m_held[i] = rd(m_addr[i]);
                    m_owner[i] = 0;
                end
                if (e_cw[i]) begin
                    m_owner[i] = 1; m_t0[i] = cyc; m_we[i] = cpu_we[i]; m_addr[i] = cpu_addr[i];
                end
                if (e_dw[i]) begin
                    m_owner[i] = 2; m_t0[i] = cyc; m_we[i] = dma_we[i]; m_addr[i] = dma_addr[i];
                    m_grants[i]++;
                end
            end
        end
        cyc++;
    end

    task automatic cpu_op(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output int ens, output logic [31:0] rdv,
                          output logic iwe, output logic [31:0] iaddr, output logic [31:0] iwd);
        logic done;
        cpu_req[i] = 1; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
        stalls = 0; ens = 0; rdv = 'x; iwe = 0; iaddr = 0; iwd = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_en[i]) begin
                ens++; iwe = mem_we[i]; iaddr = mem_addr[i]; iwd = mem_wdata[i];
            end
            done = !cpu_stall[i];
            if (done) rdv = cpu_rdata[i];
            else stalls++;
            @(posedge clk); #1;
            if (done) break;
        end
        cpu_req[i] = 0; cpu_we[i] = 0;
    endtask

    task automatic dma_op(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rdv);
        logic ok;
        dma_valid[i] = 1; dma_we[i] = we; dma_addr[i] = a; dma_wdata[i] = d;
        lat = -1; rdv = 0; ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ok = dma_ready[i];
            @(posedge clk); #1;
            if (ok) break;
        end
        dma_valid[i] = 0; dma_we[i] = 0;
        for (int k = 1; k < 50 && ok; k++) begin
            @(negedge clk);
            if (dma_rvalid[i]) begin
                lat = k; rdv = dma_rdata[i];
            end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
    endtask

    int          st, en_n, lat, ngr, rdy_c, gr_after, rv_c, gnt, nrv;
    logic        iwe, stall9;
    logic [31:0] rdv, iaddr, iwd, rvd;

    initial begin
        reset = 0;
        for (int i = 0; i < N; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0;
            dma_valid[i] = 0; dma_we[i] = 0; dma_addr[i] = 0; dma_wdata[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;

        cpu_op(0, 0, 32'h10, 0, st, en_n, rdv, iwe, iaddr, iwd);
        chk("t1_stall_cycles", 0, st, 1);
        chk("t1_mem_en_pulses", 0, en_n, 1);
        chk("t1_load_data", 0, rdv, 32'hDEADBEEF);

        cpu_op(0, 1, 32'h20, 32'h1234, st, en_n, rdv, iwe, iaddr, iwd);
        chk("t2_stall_cycles", 0, st, 1);
        chk("t2_mem_en_pulses", 0, en_n, 1);
        chk("t2_mem_we", 0, 32'(iwe), 1);
        chk("t2_mem_addr", 0, iaddr, 32'h20);
        chk("t2_mem_wdata", 0, iwd, 32'h1234);
        chk("t2_rdata_held", 0, rdv, 32'hDEADBEEF);

        cpu_req[0] = 1; cpu_addr[0] = 32'h100; dma_valid[0] = 1; dma_addr[0] = 32'h200;
        ngr = 0; rdy_c = -1; gr_after = -1; stall9 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dma_ready[0]) rdy_c = c;
            else if (mem_en[0] && rdy_c < 0) ngr++;
            else if (mem_en[0] && gr_after < 0) gr_after = c;
            if (c == 9) stall9 = cpu_stall[0];
            @(posedge clk); #1;
            if (rdy_c >= 0) dma_valid[0] = 0;
        end
        cpu_req[0] = 0;
        chk("t3_cpu_grants_before_dma", 0, ngr, 4);
        chk("t3_dma_grant_cycle", 0, rdy_c, 8);
        chk("t3_stall_during_dma", 0, 32'(stall9), 1);
        chk("t3_cpu_resume_cycle", 0, gr_after, 10);

        dma_op(0, 1, 32'h300, 32'hABCD, lat, rdv);
        chk("t3_dma_write_latency", 0, lat, 1);

        dma_valid[1] = 1; dma_we[1] = 0; dma_addr[1] = 32'h40;
        @(negedge clk);
        chk("t4_ready_cycle0", 1, 32'(dma_ready[1]), 1);
        @(posedge clk); #1;
        dma_valid[1] = 0; cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h44;
        rv_c = -1; gnt = -1; rvd = 0;
        for (int c = 1; c < 12 && gnt < 0; c++) begin
            @(negedge clk);
            if (dma_rvalid[1]) begin
                rv_c = c; rvd = dma_rdata[1];
            end
            if (mem_en[1]) gnt = c;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!cpu_stall[1]) break;
        end
        @(posedge clk); #1;
        cpu_req[1] = 0;
        chk("t4_rvalid_cycle", 1, rv_c, 3);
        chk("t4_dma_rdata", 1, rvd, 32'hCAFEF00D);
        chk("t4_next_grant_cycle", 1, gnt, 4);

        dma_valid[1] = 1; dma_we[1] = 1; dma_addr[1] = 32'h80; dma_wdata[1] = 32'h55;
        @(negedge clk);
        chk("t5_ready", 1, 32'(dma_ready[1]), 1);
        @(posedge clk); #1;
        dma_valid[1] = 0; dma_we[1] = 0;
        @(negedge clk);
        @(posedge clk); #1;
        cpu_req[1] = 1; cpu_addr[1] = 32'h10;
        reset = 0;
        #1;
        chk("t5_rst_rvalid", 1, 32'(dma_rvalid[1]), 0);
        chk("t5_rst_mem_en", 1, 32'(mem_en[1]), 0);
        chk("t5_rst_stall", 1, 32'(cpu_stall[1]), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("t5_post_reset_grant", 1, 32'(mem_en[1]), 1);
        chk("t5_post_reset_addr", 1, mem_addr[1], 32'h10);
        nrv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (dma_rvalid[1]) nrv++;
            if (!cpu_stall[1]) break;
        end
        chk("t5_post_reset_load", 1, cpu_rdata[1], 32'hDEADBEEF);
        chk("t5_no_stale_rvalid", 1, nrv, 0);
        @(posedge clk); #1;
        cpu_req[1] = 0;

        cpu_op(2, 0, 32'h10, 0, st, en_n, rdv, iwe, iaddr, iwd);
        chk("t6_stall_a", 2, st, 2);
        cpu_op(2, 0, 32'h14, 0, st, en_n, rdv, iwe, iaddr, iwd);
        chk("t6_stall_b", 2, st, 2);
        chk("t6_load_b", 2, rdv, 32'h0014FFEB);
        cpu_op(2, 0, 32'h18, 0, st, en_n, rdv, iwe, iaddr, iwd);
        chk("t6_stall_c", 2, st, 2);
        dma_op(2, 0, 32'h40, 0, lat, rdv);
        chk("t6_dma_latency", 2, lat, 2);
        chk("t6_dma_rdata", 2, rdv, 32'hCAFEF00D);
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        chk("t6_stat_stall_cyc", 2, stat_stall_cyc[2], 6);
        chk("t6_stat_dma_grants", 2, 32'(stat_dma_grants[2]), 1);
`endif
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between the pipeline MEM stage (CPU) and a DMA/loader requester.
- Issues one memory access at a time, tracks its fixed read latency, and returns read data to the owner.
- Drives the pipeline-wide stall while a CPU access is outstanding.
- CPU has priority; a starvation counter guarantees DMA forward progress.

Parameters:
- MEM_LAT, 1, cycles from memory sampling mem_en to mem_rdata valid (legal 1..4).
- STARVE_MAX, 8, consecutive cycles DMA may be refused before it wins priority (legal 1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request (MemRead|MemWrite).
- cpu_we  in  1  1 = store.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- dma_valid  in  1  DMA request valid.
- dma_we  in  1  1 = write.
- dma_addr  in  32  DMA address.
- dma_wdata  in  32  DMA write data.
- dma_ready  out  1  DMA request accepted this cycle.
- dma_rvalid  out  1  DMA access complete; dma_rdata valid for reads.
- dma_rdata  out  32  DMA read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset (async, reset=0): state IDLE, lat_cnt=0, starve_cnt=0. All outputs 0. Any in-flight access is abandoned.
- FSM states: IDLE, BUSY_CPU, BUSY_DMA. Grants are made only in IDLE.
- IDLE grant rule:
  - CPU wins if cpu_req=1 and (starve_cnt<STARVE_MAX or dma_valid=0).
  - Otherwise DMA wins if dma_valid=1.
  - Otherwise stay in IDLE.
- Issue cycle (cycle 0):
  - mem_en=1; mem_we/mem_addr/mem_wdata come combinationally from the winner.
  - A DMA win sets dma_ready=1 for that cycle.
  - Next state is BUSY_x with lat_cnt=1.
- BUSY_x: mem_en=0; lat_cnt increments each cycle. The cycle with lat_cnt==MEM_LAT is the done cycle; the state returns to IDLE at its end.
- Done cycle:
  - CPU owner: cpu_rdata=mem_rdata (combinational); the register captures it for hold.
  - DMA owner: dma_rvalid=1 and dma_rdata=mem_rdata, for both reads and writes.
- Latency: an access takes cycles 0..MEM_LAT. The next grant is possible at cycle MEM_LAT+1.
- cpu_stall = cpu_req & ~cpu_done, where cpu_done is high only in a CPU done cycle.
  - A CPU access therefore stalls for MEM_LAT cycles (1 with defaults).
  - cpu_stall is also high while DMA is busy or DMA wins over a pending cpu_req.
- Outside its done cycle, cpu_rdata holds the last CPU load value. Store completions leave it unchanged.
- dma_ready=0 in every BUSY state, so a DMA requester holds its request (valid/ready). At most one access is outstanding.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, in each IDLE cycle where dma_valid=1 and the CPU is granted.
  - Also increments in each BUSY_CPU cycle where dma_valid=1.
  - Clears on a DMA grant, and when dma_valid=0.
- Simultaneous requests with starve_cnt==STARVE_MAX: DMA wins; the CPU stays stalled until the DMA access finishes and the CPU is granted at the following IDLE.
- cpu_req dropping while BUSY_CPU (only possible on reset-driven flush): the access still completes; its result is discarded and cpu_stall follows cpu_req.
- mem_addr is passed unmodified; no alignment check.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined: adds outputs stat_stall_cyc (32, counts cycles with cpu_stall=1) and stat_dma_grants (16, counts DMA grants). Both counters saturate and clear on reset.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds: the state encoding (IDLE=2'd0, BUSY_CPU=2'd1, BUSY_DMA=2'd2), DATA_W=32, ADDR_W=32, MEM_LAT_MAX=4.
- Natural sub-module: arb_starve_ctr (saturating counter; inputs inc, clr; output at_max).

Test Plan:
- CPU load at 0x10, mem returns 0xDEADBEEF, MEM_LAT=1 -> cpu_stall=1 for exactly 1 cycle; cpu_rdata=0xDEADBEEF in done cycle; mem_en pulses once.
- CPU store 0x20<-0x1234 with dma_valid=0 -> one mem_en with mem_we=1, mem_addr=0x20, mem_wdata=0x1234; cpu_rdata unchanged.
- DMA read 0x40 alone, MEM_LAT=3 -> dma_ready in cycle 0, dma_rvalid and correct data in cycle 3; next grant no earlier than cycle 4.
- cpu_req held continuously plus dma_valid held, STARVE_MAX=8 -> DMA granted once starve_cnt reaches 8; cpu_stall stays high during DMA; CPU resumes afterwards.
- Assert reset mid-BUSY_DMA -> all outputs 0 immediately; no dma_rvalid; first post-reset cpu_req is granted at cycle 0.
- With DMEM_ARB_STATS_EN: 3 CPU loads (MEM_LAT=2) plus 1 DMA -> stat_stall_cyc=6, stat_dma_grants=1.
